// File: rtl/hilo_seq_pkg.sv
// Shared HI/LO sequencer definitions: op encodings, FSM state codes and defaults.
package hilo_seq_pkg;
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam int TIMEOUT_DEF    = 48;
    localparam int ARM_CYCLES_DEF = 2;
    localparam int WD_W           = 16;
    localparam int ARM_W          = 8;
endpackage

// File: rtl/hilo_seq_op_watchdog.sv
// Per-operation cycle watchdog; expired is high in the cycle the limit is reached.
module op_watchdog
    import hilo_seq_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    input  logic [WD_W-1:0] limit,
    output logic            expired
);
    logic [WD_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != '1)
            count <= count + WD_W'(1);
    end

    // count holds cycles already spent, so the current cycle is number count+1
    assign expired = enable && (({1'b0, count} + (WD_W+1)'(1)) >= {1'b0, limit});
endmodule

// File: rtl/hilo_seq.sv
// HI/LO sequencer: launches the multiplier or divider, captures its result,
// and handles direct HI/LO writes, divide-by-zero and unit hang timeouts.
module hilo_seq
    import hilo_seq_pkg::*;
#(
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int ARM_CYCLES = ARM_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] wr_data,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic        div_done,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_zero,
    output logic        mult_ctrl,
    output logic        div_ctrl,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        error
);
    logic [2:0]       state, state_nx;
    logic             sel_div;
    logic [ARM_W-1:0] arm_cnt;
    logic             mt_done;
    logic             wd_expired;
    logic             unit_done;
    logic             arm_last;

    assign unit_done = sel_div ? div_done : mult_done;
    assign arm_last  = (int'(arm_cnt) + 1) >= ARM_CYCLES;

    op_watchdog u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ST_IDLE),
        .enable  (state == ST_ARM || state == ST_WAIT),
        .limit   (WD_W'(TIMEOUT)),
        .expired (wd_expired)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start && !op[1]) state_nx = ST_ARM;
            ST_ARM:     if (wd_expired) state_nx = ST_RELEASE;
                        else if (arm_last) state_nx = ST_WAIT;
            // a real completion wins over a simultaneous timeout
            ST_WAIT:    if (unit_done) state_nx = ST_CAPTURE;
                        else if (wd_expired) state_nx = ST_RELEASE;
            ST_CAPTURE: state_nx = ST_RELEASE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            sel_div <= 1'b0;
            arm_cnt <= '0;
            mt_done <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            error   <= 1'b0;
        end else begin
            state   <= state_nx;
            mt_done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    if (op == OP_MTHI) begin
                        hi      <= wr_data;
                        mt_done <= 1'b1;
                    end else if (op == OP_MTLO) begin
                        lo      <= wr_data;
                        mt_done <= 1'b1;
                    end else begin
                        sel_div <= op[0];
                        error   <= 1'b0;
                        arm_cnt <= '0;
                    end
                end
                ST_ARM: begin
                    arm_cnt <= arm_cnt + ARM_W'(1);
                    if (wd_expired) error <= 1'b1;
                end
                ST_WAIT: if (!unit_done && wd_expired) error <= 1'b1;
                ST_CAPTURE: begin
                    if (sel_div && div_zero) begin
                        error <= 1'b1;
                    end else if (sel_div) begin
                        hi <= div_hi;
                        lo <= div_lo;
                    end else begin
                        hi <= mult_hi;
                        lo <= mult_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    // ctrl is low in RELEASE, which re-initializes the unit for the next launch
    assign busy      = (state == ST_ARM) || (state == ST_WAIT) || (state == ST_CAPTURE);
    assign mult_ctrl = busy && !sel_div;
    assign div_ctrl  = busy && sel_div;
    assign done      = mt_done || (state == ST_RELEASE);
endmodule

// File: doc/hilo_seq.md
HILO_SEQ -- requirements
Module: hilo_seq

Interface
REQ-001 SHALL have parameters: TIMEOUT, default 48, watchdog cycle limit per operation; ARM_CYCLES, default 2, cycles during which unit done inputs are ignored after launch.
REQ-002 SHALL have port: clock  in  1  rising-edge system clock.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  in  1  one-cycle request from control unit; sampled only in IDLE.
REQ-005 SHALL have port: op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO; sampled with start.
REQ-006 SHALL have port: wr_data  in  32  source value for MTHI/MTLO.
REQ-007 SHALL have ports: mult_done  in  1, mult_hi  in  32, mult_lo  in  32  multiplier results.
REQ-008 SHALL have ports: div_done  in  1, div_hi  in  32, div_lo  in  32, div_zero  in  1  divider results and divide-by-zero flag.
REQ-009 SHALL have ports: mult_ctrl  out  1, div_ctrl  out  1  level enables held to the units for the whole operation.
REQ-010 SHALL have ports: hi  out  32, lo  out  32  architectural HI/LO registers.
REQ-011 SHALL have ports: busy  out  1  (stall for mfhi/mflo), done  out  1  one-cycle completion pulse, error  out  1  sticky fault flag.

Function
REQ-012 SHALL implement states IDLE, ARM, WAIT, CAPTURE, RELEASE.
REQ-013 IDLE + start + op MULT/DIV SHALL latch op, clear error, assert the selected ctrl, go to ARM; busy high from the next cycle.
REQ-014 IDLE + start + op MTHI/MTLO SHALL write wr_data into hi/lo the next edge, pulse done that cycle, leave the other register unchanged, no busy.
REQ-015 ARM SHALL last ARM_CYCLES cycles, ignoring done inputs (a stale done from the previous operation SHALL NOT complete the new one), then go to WAIT.
REQ-016 WAIT SHALL go to CAPTURE on the first cycle the selected done input is high; the other unit's done SHALL be ignored.
REQ-017 CAPTURE SHALL load hi/lo from the selected unit's result ports, drop ctrl, and go to RELEASE.
REQ-018 RELEASE SHALL hold ctrl low for exactly one cycle (forcing unit re-initialization), pulse done, then return to IDLE.
REQ-019 DIV with div_zero high at capture SHALL leave hi/lo unchanged and set error.
REQ-020 A watchdog counter SHALL count cycles in ARM+WAIT; reaching TIMEOUT SHALL set error, drop ctrl, go to RELEASE, leave hi/lo unchanged.
REQ-021 MULT latency start-to-done SHALL equal unit latency (34 cycles for the 32-iteration Booth multiplier) + 3.
REQ-022 start while busy SHALL be ignored; no queueing.
REQ-023 busy SHALL be high in ARM, WAIT, CAPTURE and low in IDLE and RELEASE.
REQ-024 mult_ctrl and div_ctrl SHALL never be high simultaneously.

Reset
REQ-025 reset low SHALL immediately force IDLE, hi=0, lo=0, mult_ctrl=0, div_ctrl=0, busy=0, done=0, error=0, watchdog=0.
REQ-026 reset mid-operation SHALL abort without capture; the unit is re-initialized by ctrl low.

Structure
REQ-027 Op encodings, state encoding, and TIMEOUT/ARM_CYCLES defaults SHALL live in the shared processor package.
REQ-028 The watchdog SHALL be one sub-module, op_watchdog (clear, enable, limit, expired).

Verification
REQ-029 MULT with a real multiplier, A=7, B=-3 -> done at cycle 37, hi=FFFFFFFF, lo=FFFFFFEB, error=0.
REQ-030 MTHI wr_data=12345678 then MTLO wr_data=9ABCDEF0 -> hi=12345678, lo=9ABCDEF0, done pulse each, busy never high.
REQ-031 DIV with div_done high after 10 cycles and div_zero=1 -> hi/lo unchanged, error=1, done pulse.
REQ-032 MULT with mult_done stuck low -> error=1 at cycle TIMEOUT+1, mult_ctrl low, hi/lo unchanged, returns to IDLE.
REQ-033 MULT with mult_done held high from a prior operation, and a second start during busy -> no early completion, second start ignored.
REQ-034 reset asserted in WAIT -> all outputs zero in the same cycle, no done pulse, next MULT completes normally.
